zero_cross_freq_meter: RTL
==========================

# zero_cross_freq_meter

Parametrised gated frequency meter for signed audio samples from the codec read path. Counts hysteresis-qualified rising zero crossings over a programmable number of sample strobes and publishes a latched count with a valid pulse. With the default gate of 48000 samples at 48 kHz, the count equals the frequency in Hz. Supports single-shot and continuous measurement, abort, and overflow saturation. Feeds the tuner display and comparison logic.

## Interface
- SAMPLE_W, 24: sample width (two's complement).
- COUNT_W, 16: result width.
- GATE_SAMPLES, 48000: valid samples per measurement window; must be ≥1.
- HYST, 256: hysteresis threshold; 0 ≤ HYST < 2^(SAMPLE_W-1).
- clk  in  1  system clock; all logic is rising-edge.
- resetn  in  1  reset, asynchronous, active-low.
- sample_valid  in  1  one-cycle strobe; sample is valid in this cycle.
- sample  in  SAMPLE_W  signed audio sample.
- start  in  1  one-cycle request to begin a measurement.
- continuous  in  1  1: re-gate automatically after each result. Sampled at each gate end.
- abort  in  1  return to IDLE; freq is not updated.
- freq  out  COUNT_W  latched crossing count of the last completed gate.
- freq_valid  out  1  one-cycle pulse when freq updates.
- overflow  out  1  latched with freq; 1 if the count saturated.
- busy  out  1  high in ARM or GATE.

## Operation
- States: IDLE, ARM, GATE.
- IDLE:
  - start → ARM.
  - start is ignored outside IDLE.
- ARM:
  - Waits for a valid sample outside the hysteresis band. sample ≥ +HYST sets sign=POS; sample ≤ −HYST sets sign=NEG.
  - That qualifying sample moves the FSM to GATE.
  - It clears cross_cnt and gate_cnt.
  - It does not count toward the gate.
  - In-band samples are ignored.
- GATE, on each sample_valid:
  - If sign=NEG and sample ≥ +HYST: sign←POS and a crossing is counted.
  - If sign=POS and sample ≤ −HYST: sign←NEG.
  - In-band samples leave sign unchanged.
  - gate_cnt increments by 1.
- Crossing count saturates at 2^COUNT_W−1. Any increment attempted at saturation sets the internal ovf flag.
- Gate end (the valid sample that makes gate_cnt reach GATE_SAMPLES):
  - That sample's own crossing is included.
  - freq←final count; overflow←ovf; freq_valid pulses.
  - If continuous=1: stay in GATE and clear the counters. Sign is retained, so there is no re-arm and no sample is lost.
  - Otherwise → IDLE.
- abort has priority over all other inputs in any state:
  - → IDLE and clears the counters.
  - freq and overflow hold; no freq_valid.
- Comparisons are signed. HYST is sign-extended to SAMPLE_W.
- gate_cnt width is $clog2(GATE_SAMPLES+1).

## Timing
- Reset values (asserted asynchronously while resetn=0):
  - State IDLE, sign=NEG, counters 0.
  - freq=0, overflow=0, freq_valid=0, busy=0.
- start in cycle t → busy=1 from t+1.
- Qualifying sample in ARM at cycle t → GATE from t+1.
- Last gate sample at cycle t → freq, overflow and freq_valid registered at t+1.
  - freq_valid is high for exactly that cycle.
  - Single-shot: busy=0 from t+1.
- Continuous: a sample_valid at t+1 is the first sample of the next gate.
- Back-to-back sample_valid on consecutive cycles is supported at full rate.
- start and abort in the same cycle: abort wins and the FSM stays in IDLE.
- resetn deassertion is synchronised internally. The first active edge is the second clk rising edge after release.

## Test plan
Default parameters unless noted.
- **Basic gate** (GATE_SAMPLES=48, HYST=256): square wave −1000×4 / +1000×4, starting negative, strobe every 4 clk, start once.
  - One freq_valid pulse, 1 clk after the 48th gated sample.
  - freq=6, overflow=0, busy falls the same cycle.
- **Hysteresis** (GATE_SAMPLES=48): samples alternating +100 / −100, with one leading −1000 to arm.
  - freq=0.
  - Repeat with HYST=0 and alternating ±1000 → freq=24.
- **Overflow** (COUNT_W=4, GATE_SAMPLES=48): alternating ±1000 every sample.
  - freq=15, overflow=1.
  - The next normal run reports overflow=0.
- **Continuous** (GATE_SAMPLES=48): basic square wave with continuous=1, 3 windows.
  - freq_valid every 48 samples with no gap.
  - freq=6 each window.
  - Clearing continuous mid-window → IDLE after that window.
- **Abort/start collisions**:
  - abort mid-GATE → IDLE next cycle; freq keeps its previous value (6); no pulse.
  - start while busy → no effect.
  - start+abort in the same cycle → IDLE.
- **Reset mid-operation**: drop resetn asynchronously between clk edges during GATE.
  - All outputs go to 0 immediately.
  - After release, a start gives a correct freq=6.

Source files
------------

// File: rtl/zero_cross_freq_meter_if.sv
// Sample-stream and result bundle shared by the zero-crossing frequency meter
// and whatever feeds it samples / consumes its measurements.
interface zero_cross_freq_meter_if #(
  parameter int SAMPLE_W = 24,
  parameter int COUNT_W  = 16
);
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample;
  logic                       start;
  logic                       continuous;
  logic                       abort;
  logic        [COUNT_W-1:0]  freq;
  logic                       freq_valid;
  logic                       overflow;
  logic                       busy;

  modport master (
    output sample_valid, sample, start, continuous, abort,
    input  freq, freq_valid, overflow, busy
  );

  modport slave (
    input  sample_valid, sample, start, continuous, abort,
    output freq, freq_valid, overflow, busy
  );
endinterface

// File: rtl/zero_cross_freq_meter.sv
// Gated frequency meter: counts hysteresis-qualified rising zero crossings over
// GATE_SAMPLES sample strobes and publishes a latched count with a valid pulse.
module zero_cross_freq_meter #(
  parameter int SAMPLE_W     = 24,
  parameter int COUNT_W      = 16,
  parameter int GATE_SAMPLES = 48000,
  parameter int HYST         = 256
) (
  input  logic                     clk,
  input  logic                     resetn,
  zero_cross_freq_meter_if.slave   bus
);

  localparam int GATE_W = $clog2(GATE_SAMPLES + 1);

  localparam logic signed [SAMPLE_W-1:0] HYST_POS  = SAMPLE_W'(HYST);
  localparam logic signed [SAMPLE_W-1:0] HYST_NEG  = -HYST_POS;
  localparam logic        [COUNT_W-1:0]  CNT_MAX   = '1;
  localparam logic        [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_GATE
  } state_t;

  // Assertion is immediate; release reaches the core one edge later, so the
  // second rising edge after resetn goes high is the first active one.
  logic rst_sync_n;

  // NOTE: every clocked process uses non-blocking (<=) assignments so all
  // registers update together from the values present before the edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_n <= 1'b0;
    else         rst_sync_n <= 1'b1;
  end

  state_t               state_q,    state_d;
  logic                 sign_pos_q, sign_pos_d;
  logic [COUNT_W-1:0]   cross_q,    cross_d;
  logic                 ovf_q,      ovf_d;
  logic [GATE_W-1:0]    gate_q,     gate_d;
  logic [COUNT_W-1:0]   freq_q,     freq_d;
  logic                 overflow_q, overflow_d;
  logic                 fvalid_q,   fvalid_d;

  logic                 is_pos, is_neg;
  logic                 rising;
  logic [COUNT_W-1:0]   cross_inc;
  logic                 ovf_inc;

  // Both operands are signed, so these are true two's-complement compares.
  assign is_pos = (bus.sample >= HYST_POS);
  assign is_neg = (bus.sample <= HYST_NEG);

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q    <= ST_IDLE;
      sign_pos_q <= 1'b0;
      cross_q    <= '0;
      ovf_q      <= 1'b0;
      gate_q     <= '0;
      freq_q     <= '0;
      overflow_q <= 1'b0;
      fvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sign_pos_q <= sign_pos_d;
      cross_q    <= cross_d;
      ovf_q      <= ovf_d;
      gate_q     <= gate_d;
      freq_q     <= freq_d;
      overflow_q <= overflow_d;
      fvalid_q   <= fvalid_d;
    end
  end

  always_comb begin
    // NOTE: every variable assigned below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    sign_pos_d = sign_pos_q;
    cross_d    = cross_q;
    ovf_d      = ovf_q;
    gate_d     = gate_q;
    freq_d     = freq_q;
    overflow_d = overflow_q;
    fvalid_d   = 1'b0;
    rising     = 1'b0;
    cross_inc  = cross_q;
    ovf_inc    = ovf_q;

    if (bus.abort) begin
      // Published result is left untouched; only the measurement is dropped.
      state_d = ST_IDLE;
      cross_d = '0;
      ovf_d   = 1'b0;
      gate_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) state_d = ST_ARM;
        end

        ST_ARM: begin
          if (bus.sample_valid && (is_pos || is_neg)) begin
            sign_pos_d = is_pos;
            cross_d    = '0;
            ovf_d      = 1'b0;
            gate_d     = '0;
            state_d    = ST_GATE;
          end
        end

        ST_GATE: begin
          if (bus.sample_valid) begin
            rising = !sign_pos_q && is_pos;
            if (rising)                   sign_pos_d = 1'b1;
            else if (sign_pos_q && is_neg) sign_pos_d = 1'b0;

            if (rising) begin
              if (cross_q == CNT_MAX) ovf_inc   = 1'b1;
              else                    cross_inc = cross_q + 1'b1;
            end

            if (gate_q == GATE_LAST) begin
              // The closing sample's own crossing is part of this result.
              freq_d     = cross_inc;
              overflow_d = ovf_inc;
              fvalid_d   = 1'b1;
              cross_d    = '0;
              ovf_d      = 1'b0;
              gate_d     = '0;
              if (!bus.continuous) state_d = ST_IDLE;
            end else begin
              cross_d = cross_inc;
              ovf_d   = ovf_inc;
              gate_d  = gate_q + 1'b1;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.freq       = freq_q;
  assign bus.overflow   = overflow_q;
  assign bus.freq_valid = fvalid_q;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule
